bin_to_7seg_seq: RTL

- Sequential, parametrised binary-to-decimal display driver that converts an N-bit unsigned value into DIGITS BCD digits using shift-add-3 (double dabble).
- Drives DIGITS active-low 7-segment displays, with optional leading-zero blanking.
- Replaces the divide/modulo display path with a start/busy/done handshake, one bit per clock, and a registered result held between conversions.
- Sits between a datapath or FSM result register and the board HEX displays.

---
 rtl/bin_to_7seg_seq_pkg.sv | 23 ++
 rtl/bin_to_7seg_seq_if.sv | 15 +
 rtl/seg7_encode.sv | 26 ++
 rtl/bin_to_7seg_seq.sv | 131 +++++++++++++
 4 files changed

// File: rtl/bin_to_7seg_seq_pkg.sv
// Shared definitions for the sequential binary-to-7-segment display driver:
// FSM state encoding and active-low segment patterns (a..g, MSB = a).
package bin_to_7seg_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bin_to_7seg_seq_if.sv
// Request/result bundle between a value producer and the display driver.
interface bin_to_7seg_seq_if #(
    parameter int unsigned N      = 10,
    parameter int unsigned DIGITS = 4
);
    logic                  start;
    logic [N-1:0]          A;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic [7*DIGITS-1:0]   HEX;

    modport master (output start, A, input busy, done, bcd, HEX);
    modport slave  (input start, A, output busy, done, bcd, HEX);
endinterface

// File: rtl/seg7_encode.sv
// One BCD digit to active-low 7-segment pattern; codes above 9 show blank.
module seg7_encode
    import bin_to_7seg_seq_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bin_to_7seg_seq.sv
// Serial double-dabble converter (one bit per clock) with a held BCD result
// register driving DIGITS active-low 7-segment displays.
module bin_to_7seg_seq
    import bin_to_7seg_seq_pkg::*;
#(
    parameter int unsigned N        = 10,
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned BLANK_LZ = 1
) (
    input  logic                clk,
    input  logic                rst,
    bin_to_7seg_seq_if.slave    bus_if
);

    localparam int unsigned CNT_W = $clog2(N + 1);
    localparam int unsigned BCD_W = 4 * DIGITS;

    state_e              state_q, state_d;
    logic [BCD_W-1:0]    bcd_work_q, bcd_work_d;
    logic [N-1:0]        bin_work_q, bin_work_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [BCD_W-1:0]    adj_c;
    logic                last_shift_c;
    logic                unused_adj_msb;

    assign last_shift_c   = (cnt_q == CNT_W'(N - 1));
    // Top digit never reaches 8 for legal N/DIGITS, so its MSB is shifted out as zero.
    assign unused_adj_msb = adj_c[BCD_W-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus_if.start) state_d = ST_SHIFT;
            ST_SHIFT: if (last_shift_c) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Per-digit add-3 correction; no carry crosses digit boundaries.
    always_comb begin
        adj_c = bcd_work_q;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (bcd_work_q[4*k +: 4] >= 4'd5)
                adj_c[4*k +: 4] = bcd_work_q[4*k +: 4] + 4'd3;
        end
    end

    always_comb begin
        bcd_work_d = bcd_work_q;
        bin_work_d = bin_work_q;
        cnt_d      = cnt_q;
        bcd_d      = bcd_q;
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
        case (state_q)
            ST_IDLE: begin
                if (bus_if.start) begin
                    bcd_work_d = '0;
                    bin_work_d = bus_if.A;
                    cnt_d      = '0;
                end
            end
            ST_SHIFT: begin
                bcd_work_d = {adj_c[BCD_W-2:0], bin_work_q[N-1]};
                bin_work_d = bin_work_q << 1;
                cnt_d      = cnt_q + CNT_W'(1);
                // Result register loads with the final shift so it is valid alongside done.
                if (last_shift_c) bcd_d = {adj_c[BCD_W-2:0], bin_work_q[N-1]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_work_q <= '0;
            bin_work_q <= '0;
            cnt_q      <= '0;
            bcd_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            bcd_work_q <= bcd_work_d;
            bin_work_q <= bin_work_d;
            cnt_q      <= cnt_d;
            bcd_q      <= bcd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    logic [6:0]          seg_c [DIGITS];
    logic [DIGITS-1:0]   blank_c;
    logic [7*DIGITS-1:0] hex_c;

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
        seg7_encode u_enc (
            .bcd_i (bcd_q[4*g +: 4]),
            .seg_o (seg_c[g])
        );
    end

    // Leading-zero blanking walks from the most significant digit down; digit 0 always shows.
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        blank_c  = '0;
        hex_c    = '0;
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            all_zero   = all_zero & (bcd_q[4*k +: 4] == 4'd0);
            blank_c[k] = (BLANK_LZ != 0) && (k > 0) && all_zero;
            hex_c[7*k +: 7] = blank_c[k] ? SEG_BLANK : seg_c[k];
        end
    end

    assign bus_if.busy = busy_q;
    assign bus_if.done = done_q;
    assign bus_if.bcd  = bcd_q;
    assign bus_if.HEX  = hex_c;

endmodule
